stack_arbiter: RTL and testbench

Round-robin controller that shares one `stack` instance (push/pop LIFO, parameterised `DATA_WIDTH`/`STACK_DEPTH`) between two requesters. It sits between the requesters and the stack's control pins, and serialises push and pop operations into single-cycle stack strobes. It checks the full and empty flags before every strobe and returns a per-request acknowledge, pop data and error status. The stack itself stays outside this block and connects through the `stk_*` ports.

---
 rtl/stack_arb_pkg.sv | 16 +
 rtl/stack_arbiter_if.sv | 25 ++
 rtl/stack_arbiter_rr_arb2.sv | 22 ++
 rtl/stack_arbiter.sv | 149 ++++++++++++++
 tb/tb_stack_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/stack_arb_pkg.sv
// Shared types and constants for the two-requester stack arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stack_arb_pkg;

    localparam int   NUM_REQ = 2;
    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        COMPLETE = 2'd2
    } state_t;

endpackage

// File: rtl/stack_arbiter_if.sv
// Requester-side bundle: request/op/data in, ack/err/rdata back.
// Latency: n/a (wires only).
// Backpressure: req is held until the one-cycle ack pulse.
interface stack_arbiter_if
    import stack_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 3
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            op;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]            ack;
    logic [NUM_REQ-1:0]            err;
    logic [DATA_WIDTH-1:0]         rdata;

    modport master (
        output req, op, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, op, wdata,
        output ack, err, rdata
    );
endinterface

// File: rtl/stack_arbiter_rr_arb2.sv
// Two-way round-robin pick from the request vector and last-grant pointer.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_grant,
    output logic       o_valid
);

    // on a tie the requester not served last time wins
    always_comb begin
        o_valid = |i_req;
        o_grant = 1'b0;
        if (i_req == 2'b11) begin
            o_grant = ~i_last;
        end else if (i_req[1]) begin
            o_grant = 1'b1;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one external LIFO stack between two requesters (optional stats: STACK_ARB_STATS_EN).
// Latency: request seen in IDLE at N -> strobe N+1 -> ack/rdata N+2; one op per 3 cycles.
// Backpressure: requesters hold req until ack; full/empty rejects return err instead of stalling.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    stack_arbiter_if.slave        bus,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic                  stk_read_more,
    output logic [DATA_WIDTH-1:0] stk_data_in,
    input  logic [DATA_WIDTH-1:0] stk_data_out,
    input  logic                  stk_full,
    input  logic                  stk_empty,
    input  logic                  stk_error
`ifdef STACK_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_WIDTH-1:0] rej_cnt
`endif
);

    state_t                r_state;
    state_t                w_next;
    logic                  r_grant;
    logic                  r_last;
    logic                  r_op;
    logic                  r_rej;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [NUM_REQ-1:0]    w_ack;
    logic [NUM_REQ-1:0]    w_err;
    logic                  w_arb_grant;
    logic                  w_arb_vld;
    logic                  w_rej;
    logic                  w_pop_ok;

    rr_arb2 u_rr_arb2 (
        .i_req   (bus.req),
        .i_last  (r_last),
        .o_grant (w_arb_grant),
        .o_valid (w_arb_vld)
    );

    // the reject decision uses the flags as seen during ISSUE only
    assign w_rej         = (r_op == OP_PUSH) ? stk_full : stk_empty;
    assign w_pop_ok      = (r_op == OP_POP) && !r_rej;
    assign stk_data_in   = r_wdata;
    assign stk_read_more = 1'b0;
    assign bus.ack       = w_ack;
    assign bus.err       = w_err;
    assign bus.rdata     = w_rdata;

    // state register; reset aborts any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next state plus strobe/ack outputs decoded from the current state
    always_comb begin
        w_next   = r_state;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        w_ack    = '0;
        w_err    = '0;
        w_rdata  = r_rdata;
        case (r_state)
            IDLE: begin
                if (w_arb_vld) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                stk_push = (r_op == OP_PUSH) && !w_rej;
                stk_pop  = (r_op == OP_POP)  && !w_rej;
                w_next   = COMPLETE;
            end
            COMPLETE: begin
                w_ack[r_grant] = 1'b1;
                w_err[r_grant] = r_rej | stk_error;
                if (w_pop_ok) begin
                    w_rdata = stk_data_out;
                end
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // capture the winner in IDLE, the reject flag in ISSUE, pointer/rdata in COMPLETE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_op    <= OP_POP;
            r_rej   <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_vld) begin
                        r_grant <= w_arb_grant;
                        r_op    <= bus.op[w_arb_grant];
                        r_wdata <= w_arb_grant ? bus.wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                               : bus.wdata[DATA_WIDTH-1:0];
                    end
                end
                ISSUE: begin
                    r_rej <= w_rej;
                end
                COMPLETE: begin
                    r_last  <= r_grant;
                    r_rdata <= w_rdata;
                end
                default: begin
                    r_rej <= 1'b0;
                end
            endcase
        end
    end

`ifdef STACK_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_WIDTH-1:0] r_rej_cnt;

    // per-requester saturating reject count, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rej_cnt <= '0;
        end else if (r_state == COMPLETE && r_rej && r_rej_cnt[r_grant] != {CNT_WIDTH{1'b1}}) begin
            r_rej_cnt[r_grant] <= r_rej_cnt[r_grant] + 1'b1;
        end
    end

    assign rej_cnt = r_rej_cnt;
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: behavioural stack device plus transaction-level reference.
// Latency: checks strobe at N+1 and ack/rdata at N+2 for each operation.
// Backpressure: requests held until ack, then dropped or renewed.
module tb_stack_arbiter;

    localparam int DW    = 3;
    localparam int CW    = 8;
    localparam int DEPTH = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stk_push;
    logic          stk_pop;
    logic          stk_read_more;
    logic [DW-1:0] stk_data_in;
    logic [DW-1:0] stk_data_out;
    logic          stk_full;
    logic          stk_empty;
    logic          stk_error = 1'b0;
`ifdef STACK_ARB_STATS_EN
    logic [2*CW-1:0] rej_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    stack_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    stack_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .stk_push      (stk_push),
        .stk_pop       (stk_pop),
        .stk_read_more (stk_read_more),
        .stk_data_in   (stk_data_in),
        .stk_data_out  (stk_data_out),
        .stk_full      (stk_full),
        .stk_empty     (stk_empty),
        .stk_error     (stk_error)
`ifdef STACK_ARB_STATS_EN
        ,
        .rej_cnt       (rej_cnt)
`endif
    );

    always #5 clk = ~clk;

    // external stack device: read data appears the cycle after a pop strobe
    logic [DW-1:0] dev_mem [DEPTH];
    int            dev_cnt = 0;
    assign stk_full  = (dev_cnt == DEPTH);
    assign stk_empty = (dev_cnt == 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dev_cnt      <= 0;
            stk_data_out <= '0;
        end else if (stk_push && dev_cnt < DEPTH) begin
            dev_mem[dev_cnt] <= stk_data_in;
            dev_cnt          <= dev_cnt + 1;
        end else if (stk_pop && dev_cnt > 0) begin
            stk_data_out <= dev_mem[dev_cnt-1];
            dev_cnt      <= dev_cnt - 1;
        end
    end

    // reference model state
    logic [DW-1:0] ref_q[$];
    bit            m_last;
    logic [DW-1:0] m_rdata;
    int            m_cnt [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ref_q.delete();
        m_last   = 1'b1;
        m_rdata  = '0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"},   32'(bus.ack), 0);
        chk({tag, "_err"},   32'(bus.err), 0);
        chk({tag, "_rdata"}, 32'(bus.rdata), 0);
        chk({tag, "_strb"},  32'({stk_push, stk_pop}), 0);
        chk({tag, "_din"},   32'(stk_data_in), 0);
`ifdef STACK_ARB_STATS_EN
        chk({tag, "_rejcnt"}, 32'(rej_cnt), 0);
`endif
    endtask

    task automatic do_reset();
        bus.req   = '0;
        stk_error = 1'b0;
        rst       = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
    endtask

    // one full operation starting from IDLE with bus.req already driven
    task automatic txn(input bit keep, input bit rnd_err);
        int            g;
        bit            psh;
        bit            rej;
        bit            se;
        logic [DW-1:0] d;
        if (bus.req == 2'b11) g = m_last ? 0 : 1;
        else                  g = bus.req[1] ? 1 : 0;
        psh = bus.op[g];
        d   = bus.wdata[g*DW +: DW];
        rej = psh ? (ref_q.size() == DEPTH) : (ref_q.size() == 0);
        se  = rnd_err ? ($urandom_range(0, 3) == 0) : 1'b0;

        @(posedge clk);
        @(negedge clk);
        chk("issue_push", 32'(stk_push), 32'(psh && !rej));
        chk("issue_pop",  32'(stk_pop),  32'(!psh && !rej));
        chk("issue_ack",  32'(bus.ack),  0);
        if (psh && !rej) chk("push_data", 32'(stk_data_in), 32'(d));
        stk_error = se;
        if (!rej) begin
            if (psh) ref_q.push_back(d);
            else     m_rdata = ref_q.pop_back();
        end
        if (rej && m_cnt[g] < (1 << CW) - 1) m_cnt[g]++;

        @(posedge clk);
        @(negedge clk);
        chk("ack",   32'(bus.ack),   32'(1) << g);
        chk("err",   32'(bus.err),   (rej || se) ? (32'(1) << g) : 32'(0));
        chk("rdata", 32'(bus.rdata), 32'(m_rdata));
        chk("cmpl_strb", 32'({stk_push, stk_pop}), 0);
`ifdef STACK_ARB_STATS_EN
        chk("rej_cnt", 32'(rej_cnt), 32'((m_cnt[1] << CW) | m_cnt[0]));
`endif
        m_last = g[0];

        @(posedge clk);
        #1;
        stk_error = 1'b0;
        if (keep) bus.wdata[g*DW +: DW] = DW'($urandom_range(0, 7));
        else      bus.req[g] = 1'b0;
    endtask

    initial begin
        bus.req   = '0;
        bus.op    = '0;
        bus.wdata = '0;
        do_reset();
        chk("read_more", 32'(stk_read_more), 0);

        // requester 0 pushes 5, requester 1 pops it back
        bus.op[0] = 1'b1; bus.wdata[2:0] = 3'b101; bus.req = 2'b01;
        txn(0, 0);
        bus.op[1] = 1'b0; bus.req = 2'b10;
        txn(0, 0);
        chk("pop_value", 32'(bus.rdata), 5);

        // pop on empty stack is rejected
        bus.op[0] = 1'b0; bus.req = 2'b01;
        txn(0, 0);

        // both push continuously from a fresh reset: alternate grants, fill, then reject
        do_reset();
        bus.op = 2'b11;
        bus.wdata = 6'($urandom_range(0, 63));
        bus.req = 2'b11;
        for (int i = 0; i < 10; i++) txn(1, 0);
        bus.req = '0;
        chk("fill_depth", 32'(ref_q.size()), DEPTH);

        // randomized mix with leftover requests and injected stack errors
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!bus.req[r] && $urandom_range(0, 1) == 1) begin
                    bus.op[r]             = 1'($urandom_range(0, 1));
                    bus.wdata[r*DW +: DW] = DW'($urandom_range(0, 7));
                    bus.req[r]            = 1'b1;
                end
            end
            if (bus.req == 2'b00) begin
                bus.op[1]          = 1'($urandom_range(0, 1));
                bus.wdata[5:3]     = DW'($urandom_range(0, 7));
                bus.req[1]         = 1'b1;
            end
            txn(0, 1);
        end
        bus.req = '0;

        // reset during ISSUE aborts the push, then normal service resumes
        do_reset();
        bus.op[0] = 1'b1; bus.wdata[2:0] = 3'd3; bus.req = 2'b01;
        @(posedge clk);
        @(negedge clk);
        chk("abort_pre_push", 32'(stk_push), 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("abort");
        bus.req = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("abort_no_ack", 32'(bus.ack), 0);
        chk("abort_dev_cnt", 32'(dev_cnt), 0);
        rst = 1'b0;
        bus.op[0] = 1'b1; bus.wdata[2:0] = 3'd6; bus.req = 2'b01;
        txn(0, 0);
        bus.op[1] = 1'b0; bus.req = 2'b10;
        txn(0, 0);
        chk("post_abort_pop", 32'(bus.rdata), 6);

        // long run of rejected pops drives the reject counter into saturation
        bus.op[0] = 1'b0; bus.req = 2'b01;
        for (int i = 0; i < 258; i++) txn(1, 0);
        bus.req = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
